// File: rtl/icache_ctrl_if.sv
// Fetch-side and backing-memory-side signals of the instruction cache.
// The cache uses the slave view; the fetch stage / memory model uses the master view.
interface icache_ctrl_if;
  logic        fetch_en;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] instr;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] miss_count;

  modport slave (
    input  fetch_en, pc, flush, mem_ack, mem_rdata,
    output instr, stall, mem_req, mem_addr, miss_count
  );

  modport master (
    output fetch_en, pc, flush, mem_ack, mem_rdata,
    input  instr, stall, mem_req, mem_addr, miss_count
  );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache (4-word lines) with an in-order 4-beat refill FSM,
// whole-cache flush and a refill counter.
module icache_ctrl #(
  parameter int unsigned NUM_SETS = 64
) (
  input logic          clk,
  input logic          rst,
  icache_ctrl_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned TAG_W = 28 - IDX_W;

  typedef enum logic [0:0] {StIdle, StRefill} state_e;

  state_e                    state_q, state_d;
  logic [1:0]                beat_q, beat_d;
  logic [TAG_W-1:0]          refill_tag_q, refill_tag_d;
  logic [IDX_W-1:0]          refill_idx_q, refill_idx_d;
  logic                      flush_pend_q, flush_pend_d;
  logic [31:0]               miss_count_q, miss_count_d;
  logic [NUM_SETS-1:0]       valid_q, valid_d;

  logic [TAG_W-1:0]          tag_q  [NUM_SETS];
  logic [31:0]               data_q [NUM_SETS][4];

  logic [TAG_W-1:0]          pc_tag;
  logic [IDX_W-1:0]          pc_idx;
  logic [1:0]                pc_off;
  logic                      unused_pc;
  logic                      hit;
  logic                      data_we;
  logic                      tag_we;
  logic                      stall;
  logic                      mem_req;
  logic [31:0]               mem_addr;

  assign pc_tag    = bus.pc[31:4+IDX_W];
  assign pc_idx    = bus.pc[3+IDX_W:4];
  assign pc_off    = bus.pc[3:2];
  assign unused_pc = ^bus.pc[1:0];

  assign hit = bus.fetch_en && (state_q == StIdle) && valid_q[pc_idx] &&
               (tag_q[pc_idx] == pc_tag);

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    refill_tag_d = refill_tag_q;
    refill_idx_d = refill_idx_q;
    flush_pend_d = flush_pend_q;
    miss_count_d = miss_count_q;
    valid_d      = valid_q;
    data_we      = 1'b0;
    tag_we       = 1'b0;
    stall        = 1'b0;
    mem_req      = 1'b0;
    mem_addr     = '0;

    case (state_q)
      StIdle: begin
        stall = bus.fetch_en && !hit;
        // The lookup above used the pre-flush valid bits.
        if (bus.flush) valid_d = '0;
        if (bus.fetch_en && !hit) begin
          refill_tag_d = pc_tag;
          refill_idx_d = pc_idx;
          beat_d       = 2'd0;
          miss_count_d = miss_count_q + 32'd1;
          state_d      = StRefill;
        end
      end
      StRefill: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {refill_tag_q, refill_idx_q, beat_q, 2'b00};
        if (bus.flush) flush_pend_d = 1'b1;
        if (bus.mem_ack) begin
          data_we = 1'b1;
          beat_d  = beat_q + 2'd1;
          // A partially written line must never hit.
          if (beat_q == 2'd0) valid_d[refill_idx_q] = 1'b0;
          if (beat_q == 2'd3) begin
            tag_we  = 1'b1;
            state_d = StIdle;
            if (flush_pend_q || bus.flush) begin
              valid_d      = '0;
              flush_pend_d = 1'b0;
            end else begin
              valid_d[refill_idx_q] = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      beat_q       <= 2'd0;
      refill_tag_q <= '0;
      refill_idx_q <= '0;
      flush_pend_q <= 1'b0;
      miss_count_q <= 32'd0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      refill_tag_q <= refill_tag_d;
      refill_idx_q <= refill_idx_d;
      flush_pend_q <= flush_pend_d;
      miss_count_q <= miss_count_d;
      valid_q      <= valid_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (!rst && data_we) data_q[refill_idx_q][beat_q] <= bus.mem_rdata;
    if (!rst && tag_we)  tag_q[refill_idx_q] <= refill_tag_q;
  end

  assign bus.instr      = data_q[pc_idx][pc_off];
  assign bus.stall      = stall;
  assign bus.mem_req    = mem_req;
  assign bus.mem_addr   = mem_addr;
  assign bus.miss_count = miss_count_q;
endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Direct-mapped instruction cache with its refill controller, sitting between the fetch stage and the backing instruction memory. It returns `instr` combinationally for the current `pc` on a hit. On a miss it raises `stall`, runs a 4-beat line refill over a valid/ack handshake, writes the line, and then retries the lookup. It also supports a whole-cache flush and counts misses.

## Interface
Parameters:
- `NUM_SETS`, default 64: number of lines, power of two ≥ 2; `IDX_W = log2(NUM_SETS)`.
- Line size is fixed at 4 words (16 bytes). Offset is `pc[3:2]`, index is `pc[3+IDX_W:4]`, tag is `pc[31:4+IDX_W]` (22 bits at default).

Ports (clock and reset first):
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fetch_en`  in  1  fetch stage requests `instr` for `pc` this cycle.
- `pc`  in  32  fetch address; bits [1:0] ignored.
- `flush`  in  1  invalidate all lines (single-cycle pulse).
- `instr`  out  32  instruction word; valid only when `fetch_en && !stall`.
- `stall`  out  1  fetch must hold `pc` and retry.
- `mem_req`  out  1  refill beat request to the backing memory.
- `mem_addr`  out  32  word-aligned beat address.
- `mem_ack`  in  1  beat accepted; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32  beat data.
- `miss_count`  out  32  number of refills started since reset; wraps at 2^32.

## Operation
- Storage: `valid[NUM_SETS]` (flops), `tag[NUM_SETS]`, `data[NUM_SETS][4]`. Reads are asynchronous, writes are synchronous.
- Hit: `fetch_en && state==IDLE && valid[idx] && tag[idx]==pc_tag`.
- Miss: `fetch_en && state==IDLE` and not a hit.
- FSM has two states, IDLE and REFILL.
- IDLE behaviour:
  - `stall = fetch_en && !hit`.
  - `mem_req = 0`.
  - On a miss: latch `refill_tag` and `refill_idx` from `pc`, set `beat = 0`, increment `miss_count`, go to REFILL.
  - `fetch_en = 0`: `stall = 0`, no refill.
- REFILL behaviour:
  - `stall = 1` and `mem_req = 1`.
  - `mem_addr = {refill_tag, refill_idx, beat[1:0], 2'b00}`.
  - On `mem_ack`: write `data[refill_idx][beat] = mem_rdata`, then `beat += 1`.
  - On the ack with `beat == 3`: write `tag[refill_idx] = refill_tag`, set `valid[refill_idx] = 1`, go to IDLE.
  - No `mem_ack`: hold all outputs stable, with no timeout.
- Beats are issued in ascending order 0..3 from the line base. Critical-word-first is not supported.
- The line is not usable until all 4 beats land. While in REFILL, `valid[refill_idx]` is cleared when the first beat is written, so partial lines never hit.
- `pc` may change during REFILL. The refill completes for the latched address, and the IDLE lookup then uses the current `pc` (which may miss again).
- Flush:
  - In IDLE: all `valid` bits are cleared at the edge. A lookup in the same cycle still uses the pre-flush valid bits.
  - In REFILL: sets `flush_pend`. When the refill completes, all valid bits are cleared, including the line just filled, and `flush_pend` is cleared.
- Reset: state = IDLE, all `valid` = 0, `beat` = 0, `flush_pend` = 0, `miss_count` = 0.
  - Resulting outputs: `mem_req = 0`, `stall = 0` while `fetch_en = 0`, `mem_addr = 0`.
  - `tag` and `data` arrays are not reset.
  - Reset during REFILL abandons the refill immediately. `mem_req` drops the next cycle and the backing memory must tolerate this.

## Timing
- Hit: zero-cycle latency. `instr` is combinational from `pc` in IDLE.
- Miss with `mem_ack` held high:
  - Cycle 0: IDLE miss, `stall = 1`.
  - Cycles 1–4: REFILL beats 0–3.
  - Cycle 5: IDLE hit, `stall = 0`.
  - Miss penalty is 5 stall cycles, and `mem_req` first rises in cycle 1.
- Each wait cycle without `mem_ack` adds one stall cycle.
- `miss_count` updates at the end of cycle 0 of each miss.

## Test plan
- Cold miss, zero-wait: reset, `fetch_en = 1`, `pc = 0x0000_0040`, ack every cycle with data `0xA0..0xA3`.
  - `mem_addr` sequence is 0x40, 0x44, 0x48, 0x4C in cycles 1–4.
  - Cycle 5: `stall = 0`, `instr = 0xA0`.
  - `pc = 0x4C` then hits with `instr = 0xA3`.
  - `miss_count = 1`.
- Wait states: same as above but `mem_ack` only every 3rd cycle → stall lasts 13 cycles and `mem_addr` holds during the waits.
- Conflict eviction: fill `pc = 0x040`, then `pc = 0x440`; both map to index 4 at default `NUM_SETS`.
  - Second access misses and refills.
  - Returning to 0x040 misses again.
  - `miss_count = 3`.
- Flush mid-refill: pulse `flush` during beat 1 of a refill for 0x80.
  - Refill completes.
  - The next cycle's lookup of 0x80 misses (new refill, `miss_count` += 1).
- Reset mid-refill: assert `rst` during beat 2.
  - Next cycle `mem_req = 0` and `miss_count = 0`.
  - Re-fetching the same `pc` misses (line not valid).
- `fetch_en = 0` with arbitrary `pc` for 10 cycles → `stall = 0`, `mem_req = 0`, `miss_count` unchanged.
